// File: rtl/ncl_multirail_pipe.sv
// Clocked model of an NCL four-phase wavefront pipeline: STAGES stages of DIGITS 1-of-RAILS digits.
// Optional input rail checker (err port) is compiled in when NCL_RAIL_CHECK_EN is defined.
module ncl_multirail_pipe #(
    parameter int DIGITS    = 1,
    parameter int RAILS     = 2,
    parameter int STAGES    = 4,
    parameter int CNT_W     = 16,
    parameter int SELF_TEST = 0
) (
    input  logic                      clk,
    input  logic                      init,
    input  logic [DIGITS*RAILS-1:0]   in_data,
    output logic                      in_comp,
    output logic [DIGITS*RAILS-1:0]   out_data,
    input  logic                      out_comp,
    output logic [CNT_W-1:0]          tok_count
`ifdef NCL_RAIL_CHECK_EN
    ,
    output logic                      err
`endif
);
    localparam int W  = DIGITS * RAILS;
    localparam int KW = (RAILS > 2) ? $clog2(RAILS) : 1;

    // Handshake: a stage with enable high accepts DATA, with enable low accepts NULL;
    // its completion goes 1 once every digit holds a rail and 0 once all rails are low.
    logic [W-1:0]      rail_q [STAGES];
    logic [W-1:0]      rail_d [STAGES];
    logic [W-1:0]      xin    [STAGES];
    logic [STAGES-1:0] comp_q, comp_d;
    logic [STAGES-1:0] en;
    logic [CNT_W-1:0]  tok_q, tok_d;
    logic [KW-1:0]     k_q, k_d;
    logic              sink_q, sink_d;
    logic [W-1:0]      src_data;
    logic [W-1:0]      x0;
    logic              last_en;

    function automatic logic all_digits_set(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (v[d*RAILS +: RAILS] == '0) ok = 1'b0;
        end
        return ok;
    endfunction

    always_comb begin
        src_data = '0;
        for (int d = 0; d < DIGITS; d++) begin
            for (int r = 0; r < RAILS; r++) begin
                if (!comp_q[0] && (((int'(k_q) + d) % RAILS) == r)) src_data[d*RAILS + r] = 1'b1;
            end
        end
        x0      = (SELF_TEST != 0) ? src_data : in_data;
        last_en = (SELF_TEST != 0) ? ~sink_q : ~out_comp;
        en      = {last_en, ~comp_q[STAGES-1:1]};

        xin[0] = x0;
        for (int s = 1; s < STAGES; s++) xin[s] = rail_q[s-1];

        // Per-bit hysteresis: follow the input only when it agrees with the enable.
        for (int s = 0; s < STAGES; s++) begin
            rail_d[s] = (xin[s] & {W{en[s]}}) | (rail_q[s] & (xin[s] | {W{en[s]}}));
            if (all_digits_set(rail_q[s]))  comp_d[s] = 1'b1;
            else if (rail_q[s] == '0)       comp_d[s] = 1'b0;
            else                            comp_d[s] = comp_q[s];
        end

        tok_d = tok_q;
        if (comp_d[STAGES-1] && !comp_q[STAGES-1]) tok_d = tok_q + CNT_W'(1);

        k_d = k_q;
        if (comp_d[0] && !comp_q[0]) k_d = (k_q == KW'(RAILS - 1)) ? '0 : k_q + KW'(1);

        if (all_digits_set(rail_q[STAGES-1]))  sink_d = 1'b1;
        else if (rail_q[STAGES-1] == '0)       sink_d = 1'b0;
        else                                   sink_d = sink_q;
    end

    always_ff @(posedge clk) begin
        if (init) begin
            for (int s = 0; s < STAGES; s++) rail_q[s] <= '0;
            comp_q <= '0;
            tok_q  <= '0;
            k_q    <= '0;
            sink_q <= 1'b0;
        end else begin
            for (int s = 0; s < STAGES; s++) rail_q[s] <= rail_d[s];
            comp_q <= comp_d;
            tok_q  <= tok_d;
            k_q    <= k_d;
            sink_q <= sink_d;
        end
    end

    assign in_comp   = comp_q[0];
    assign out_data  = rail_q[STAGES-1];
    assign tok_count = tok_q;

`ifdef NCL_RAIL_CHECK_EN
    logic [W-1:0] x0_q, x0_d;
    logic         err_q, err_d;

    // Flags multi-hot digits and DATA-to-different-DATA steps that skip the NULL phase.
    always_comb begin
        x0_d  = x0;
        err_d = err_q;
        for (int d = 0; d < DIGITS; d++) begin
            if ($countones(x0[d*RAILS +: RAILS]) > 1) err_d = 1'b1;
            if ((x0[d*RAILS +: RAILS] != '0) && (x0_q[d*RAILS +: RAILS] != '0) &&
                (x0[d*RAILS +: RAILS] != x0_q[d*RAILS +: RAILS])) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            x0_q  <= '0;
            err_q <= 1'b0;
        end else begin
            x0_q  <= x0_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif
endmodule

// File: tb/tb_ncl_multirail_pipe.sv
// Bench for ncl_multirail_pipe: directed latency/stall/partial/reset checks, a randomized
// producer/consumer run against an in-order token queue, and a SELF_TEST instance.
module tb_ncl_multirail_pipe;
    localparam int DIGITS = 2;
    localparam int RAILS  = 2;
    localparam int STAGES = 4;
    localparam int CNT_W  = 16;
    localparam int W      = DIGITS * RAILS;
    localparam int ST_D   = 2;
    localparam int ST_R   = 3;
    localparam int ST_W   = ST_D * ST_R;
    localparam int BOUND  = 200;
    localparam int NTOK   = 40;

    // clock / reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             init;
    logic [W-1:0]     in_data;
    logic             in_comp;
    logic [W-1:0]     out_data;
    logic             out_comp;
    logic [CNT_W-1:0] tok_count;

    logic             st_init;
    logic [ST_W-1:0]  st_in_data;
    logic             st_in_comp;
    logic [ST_W-1:0]  st_out_data;
    logic             st_out_comp;
    logic [CNT_W-1:0] st_tok;
`ifdef NCL_RAIL_CHECK_EN
    logic             err;
    logic             st_err;
`endif

    ncl_multirail_pipe #(.DIGITS(DIGITS), .RAILS(RAILS), .STAGES(STAGES), .CNT_W(CNT_W), .SELF_TEST(0)) dut (
        .clk(clk), .init(init), .in_data(in_data), .in_comp(in_comp),
        .out_data(out_data), .out_comp(out_comp), .tok_count(tok_count)
`ifdef NCL_RAIL_CHECK_EN
        , .err(err)
`endif
    );

    ncl_multirail_pipe #(.DIGITS(ST_D), .RAILS(ST_R), .STAGES(STAGES), .CNT_W(CNT_W), .SELF_TEST(1)) st_dut (
        .clk(clk), .init(st_init), .in_data(st_in_data), .in_comp(st_in_comp),
        .out_data(st_out_data), .out_comp(st_out_comp), .tok_count(st_tok)
`ifdef NCL_RAIL_CHECK_EN
        , .err(st_err)
`endif
    );

    int vec_cnt  = 0;
    int miss_cnt = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_data(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int d = 0; d < DIGITS; d++) if (v[d*RAILS +: RAILS] == '0) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [W-1:0] rand_data();
        logic [W-1:0] v;
        v = '0;
        for (int d = 0; d < DIGITS; d++) v[d*RAILS + $urandom_range(0, RAILS-1)] = 1'b1;
        return v;
    endfunction

    // j-th DATA wavefront of the self-test source: digit d is one-hot at (j+d) mod RAILS.
    function automatic logic [ST_W-1:0] st_code(input int j);
        logic [ST_W-1:0] v;
        v = '0;
        for (int d = 0; d < ST_D; d++) v[d*ST_R + ((j + d) % ST_R)] = 1'b1;
        return v;
    endfunction

    // driver tasks
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        init = 1'b1; in_data = '0; out_comp = 1'b0;
        cyc(2);
        init = 1'b0;
    endtask

    task automatic wait_ic(input logic val, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < BOUND; n++) begin
            if (in_comp === val) begin ok = 1'b1; return; end
            @(negedge clk);
        end
        check("in_comp_timeout", in_comp, val);
    endtask

    task automatic wait_out(input logic want_data, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < BOUND; n++) begin
            if (want_data ? is_data(out_data) : (out_data === '0)) begin ok = 1'b1; return; end
            @(negedge clk);
        end
        check(want_data ? "out_data_timeout" : "out_null_timeout", out_data, want_data ? '1 : '0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int rises;
        int changes;
        logic prev_ic, last_ic, next_b;
        logic [W-1:0] last_od;
        int st_count;
        logic st_prev;

        st_init = 1'b1; st_in_data = '1; st_out_comp = 1'b1;
        init = 1'b1; in_data = '1; out_comp = 1'b0;

        // reset holds everything at NULL even with garbage on the input
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_out_data", out_data, '0);
            check("rst_in_comp", in_comp, 1'b0);
            check("rst_tok", tok_count, '0);
        end

        // single token latency
        init = 1'b0; in_data = 4'b1001;
        @(negedge clk); check("lat_in_comp_p1", in_comp, 1'b0);
        @(negedge clk); check("lat_in_comp_p2", in_comp, 1'b1);
        @(negedge clk); check("lat_out_p3", out_data, '0);
        @(negedge clk); check("lat_out_p4", out_data, 4'b1001); check("lat_tok_p4", tok_count, 0);
        @(negedge clk); check("lat_tok_p5", tok_count, 1);

        // partial wavefront never completes
        do_reset();
        in_data = 4'b0001;
        cyc(3);
        check("partial_in_comp", in_comp, 1'b0);
        in_data = 4'b1001;
        @(negedge clk); check("partial_fill_p1", in_comp, 1'b0);
        @(negedge clk); check("partial_fill_p2", in_comp, 1'b1);
        check("partial_tok", tok_count, 0);

        // stalled consumer: pipe fills to half its depth and freezes
        do_reset();
        in_data = 4'b0101; next_b = 1'b1; rises = 0; changes = 0;
        prev_ic = 1'b0; last_ic = 1'b0; last_od = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i >= 40 && (in_comp !== last_ic || out_data !== last_od)) changes++;
            if (in_comp && !prev_ic) begin
                rises++;
                in_data = '0;
            end else if (!in_comp && prev_ic) begin
                in_data = next_b ? 4'b1010 : 4'b0101;
                next_b = ~next_b;
            end
            prev_ic = in_comp; last_ic = in_comp; last_od = out_data;
        end
        check("stall_out_data", out_data, 4'b0101);
        check("stall_accepted", rises, 2);
        check("stall_in_comp", in_comp, 1'b0);
        check("stall_frozen", changes, 0);
        check("stall_tok", tok_count, 1);

        // init in the middle of a full pipe
        init = 1'b1; in_data = '0;
        @(negedge clk);
        check("midinit_out", out_data, '0);
        check("midinit_in_comp", in_comp, 1'b0);
        check("midinit_tok", tok_count, 0);
        init = 1'b0;

`ifdef NCL_RAIL_CHECK_EN
        cyc(1);
        check("err_clear", err, 1'b0);
        in_data = 4'b0011;
        @(negedge clk); check("err_multihot", err, 1'b1);
        in_data = '0;
        cyc(2); check("err_sticky", err, 1'b1);
        init = 1'b1;
        @(negedge clk);
        check("err_init", err, 1'b0); check("err_init_out", out_data, '0); check("err_init_tok", tok_count, 0);
        init = 1'b0; in_data = 4'b0101;
        @(negedge clk); check("err_legal", err, 1'b0);
        in_data = 4'b0110;
        @(negedge clk); check("err_data_data", err, 1'b1);
`endif

        // randomized producer / consumer against the in-order scoreboard
        do_reset();
        exp_q.delete();
        fork
            begin : producer
                bit pok;
                logic [W-1:0] v;
                for (int t = 0; t < NTOK; t++) begin
                    wait_ic(1'b0, pok); if (!pok) break;
                    cyc($urandom_range(0, 2));
                    v = rand_data();
                    in_data = v;
                    exp_q.push_back(v);
                    wait_ic(1'b1, pok); if (!pok) break;
                    cyc($urandom_range(0, 2));
                    in_data = '0;
                end
            end
            begin : monitor
                bit mok;
                for (int t = 0; t < NTOK; t++) begin
                    wait_out(1'b1, mok); if (!mok) break;
                    if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
                    else check("sb_data", out_data, exp_q.pop_front());
                    cyc($urandom_range(0, 4));
                    out_comp = 1'b1;
                    wait_out(1'b0, mok); if (!mok) break;
                    cyc($urandom_range(0, 4));
                    out_comp = 1'b0;
                end
            end
        join
        cyc(3);
        check("sb_tok", tok_count, NTOK);
        check("sb_leftover", exp_q.size(), 0);

        // self-test source/sink loop
        cyc(1);
        st_init = 1'b0;
        st_count = 0; st_prev = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (st_out_data != '0 && !st_prev) begin
                check("st_code", st_out_data, st_code(st_count));
                st_count++;
            end
            st_prev = (st_out_data != '0);
        end
        @(negedge clk);
        check("st_tok", st_tok, st_count);
        check("st_progress", st_count >= 10, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
